// File: rtl/ram_pkg.sv
// rtl/ram_pkg.sv - shared types and constants for the single-port RAM controller
package ram_pkg;

    typedef enum logic [1:0] {
        ST_RST,
        ST_CLEAR,
        ST_IDLE
    } state_t;

    localparam int MAX_RD_LAT = 3;

    function automatic int strb_w(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/ram_sp_array.sv
// rtl/ram_sp_array.sv - byte-writable single-port storage array with a registered read port
module ram_sp_array
    import ram_pkg::*;
#(
    parameter int    DATA_W    = 16,
    parameter int    ADDR_W    = 8,
    parameter string INIT_FILE = ""
) (
    input  logic                      clk,
    input  logic                      clr_n,
    input  logic                      wr_en,
    input  logic [strb_w(DATA_W)-1:0] be,
    input  logic                      rd_en,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wdata,
    output logic [DATA_W-1:0]         rdata
);

    localparam int NB = strb_w(DATA_W);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Storage itself is deliberately not reset; only the read register is.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_sp_ctrl.sv
// rtl/ram_sp_ctrl.sv - single-port RAM controller with handshake, byte strobes, read pipeline and zero-fill sweep
module ram_sp_ctrl
    import ram_pkg::*;
#(
    parameter int    DATA_W       = 16,
    parameter int    ADDR_W       = 8,
    parameter int    RD_LAT       = 1,
    parameter int    CLEAR_ON_RST = 1,
    parameter string INIT_FILE    = ""
) (
    input  logic                      clk,
    input  logic                      clr_n,
    input  logic                      req,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [strb_w(DATA_W)-1:0] wstrb,
    input  logic                      flush,
    output logic                      ready,
    output logic [DATA_W-1:0]         rdata,
    output logic                      rvalid,
    output logic                      init_done
);

    localparam int NB = strb_w(DATA_W);

    state_t            state, state_nxt;
    logic [ADDR_W:0]   cnt, cnt_nxt;
    logic              init_nxt;
    logic              accept;
    logic              arr_wr, arr_rd;
    logic [NB-1:0]     arr_be;
    logic [ADDR_W-1:0] arr_addr;
    logic [DATA_W-1:0] arr_wdata, arr_rdata;
    logic [RD_LAT-1:0] vld;

    assign ready  = (state == ST_IDLE);
    assign accept = req & ready;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state     <= ST_RST;
            cnt       <= '0;
            init_done <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            init_done <= init_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        init_nxt  = init_done;
        arr_wr    = 1'b0;
        arr_rd    = 1'b0;
        arr_be    = wstrb;
        arr_addr  = addr;
        arr_wdata = wdata;
        unique case (state)
            ST_RST: begin
                cnt_nxt = '0;
                if (CLEAR_ON_RST != 0) begin
                    state_nxt = ST_CLEAR;
                end else begin
                    state_nxt = ST_IDLE;
                    init_nxt  = 1'b1;
                end
            end
            ST_CLEAR: begin
                arr_wr    = 1'b1;
                arr_be    = '1;
                arr_addr  = cnt[ADDR_W-1:0];
                arr_wdata = '0;
                cnt_nxt   = cnt + (ADDR_W+1)'(1);
                // Carry into the extra counter bit marks the last address written.
                if (cnt_nxt[ADDR_W]) begin
                    state_nxt = ST_IDLE;
                    init_nxt  = 1'b1;
                end
            end
            ST_IDLE: begin
                arr_wr = accept & we;
                arr_rd = accept & ~we;
                if (flush && !req) begin
                    state_nxt = ST_CLEAR;
                    cnt_nxt   = '0;
                end
            end
            default: state_nxt = ST_RST;
        endcase
    end

    ram_sp_array #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_array (
        .clk   (clk),
        .clr_n (clr_n),
        .wr_en (arr_wr),
        .be    (arr_be),
        .rd_en (arr_rd),
        .addr  (arr_addr),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    // The array read register is stage 0; stages 1..RD_LAT-1 live here.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            vld <= '0;
        end else begin
            vld <= RD_LAT'({vld, arr_rd});
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign rdata = arr_rdata;
        end else begin : g_latn
            logic [RD_LAT-1:1][DATA_W-1:0] dly;
            always_ff @(posedge clk or negedge clr_n) begin
                if (!clr_n) begin
                    dly <= '0;
                end else begin
                    if (vld[0]) begin
                        dly[1] <= arr_rdata;
                    end
                    for (int i = 2; i < RD_LAT; i++) begin
                        if (vld[i-1]) begin
                            dly[i] <= dly[i-1];
                        end
                    end
                end
            end
            assign rdata = dly[RD_LAT-1];
        end
    endgenerate

    assign rvalid = vld[RD_LAT-1];

endmodule

// File: tb/tb_ram_sp_ctrl.sv
// tb/tb_ram_sp_ctrl.sv - self-checking bench for ram_sp_ctrl at read latencies 2 and 3
module tb_ram_sp_ctrl;

    localparam int DW    = 16;
    localparam int AW    = 8;
    localparam int SW    = 2;
    localparam int DEPTH = 256;

    logic          clk   = 1'b0;
    logic          clr_n = 1'b0;
    logic          req   = 1'b0;
    logic          we    = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;

    logic          ready_a, rvalid_a, init_done_a;
    logic          ready_b, rvalid_b, init_done_b;
    logic [DW-1:0] rdata_a, rdata_b;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [SW-1:0] s;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    ram_sp_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .RD_LAT(2), .CLEAR_ON_RST(1), .INIT_FILE("")
    ) dut_a (
        .clk(clk), .clr_n(clr_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .flush(flush), .ready(ready_a), .rdata(rdata_a),
        .rvalid(rvalid_a), .init_done(init_done_a)
    );

    ram_sp_ctrl #(
        .DATA_W(DW), .ADDR_W(AW), .RD_LAT(3), .CLEAR_ON_RST(1), .INIT_FILE("")
    ) dut_b (
        .clk(clk), .clr_n(clr_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .wstrb(wstrb), .flush(flush), .ready(ready_b), .rdata(rdata_b),
        .rvalid(rvalid_b), .init_done(init_done_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int n0, output int n);
        n = n0;
        while (!ready_a && n < 2000) begin
            n++;
            tick();
        end
    endtask

    task automatic do_op(input vec_t v, input int idx);
        logic [3:0]    pa, pb;
        logic [DW-1:0] da, db;
        req = 1'b1; we = v.w; addr = v.a; wdata = v.d; wstrb = v.s;
        tick();
        req = 1'b0; we = 1'b0; wstrb = '0;
        pa = '0; pb = '0; da = '0; db = '0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) tick();
            pa[k] = rvalid_a;
            pb[k] = rvalid_b;
            if (rvalid_a) da = rdata_a;
            if (rvalid_b) db = rdata_b;
        end
        check($sformatf("vec%0d rvalid_a", idx), pa, v.w ? 4'b0000 : 4'b0010);
        check($sformatf("vec%0d rvalid_b", idx), pb, v.w ? 4'b0000 : 4'b0100);
        if (!v.w) begin
            check($sformatf("vec%0d rdata_a", idx), da, v.exp);
            check($sformatf("vec%0d rdata_b", idx), db, v.exp);
        end
    endtask

    int            n;
    logic [7:0]    va, vb;
    logic [DW-1:0] da8 [8];
    logic [DW-1:0] db8 [8];
    int            cnt_a, cnt_b;
    logic [DW-1:0] or_a, or_b;
    logic          v_or;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 8'h10, 16'hBEEF, 2'b11, 16'h0000};
        vecs[1]  = '{1'b0, 8'h10, 16'h0000, 2'b00, 16'hBEEF};
        vecs[2]  = '{1'b1, 8'h10, 16'h1234, 2'b01, 16'h0000};
        vecs[3]  = '{1'b0, 8'h10, 16'h0000, 2'b00, 16'hBE34};
        vecs[4]  = '{1'b1, 8'h10, 16'hFFFF, 2'b00, 16'h0000};
        vecs[5]  = '{1'b0, 8'h10, 16'h0000, 2'b00, 16'hBE34};
        vecs[6]  = '{1'b1, 8'h11, 16'h5A5A, 2'b10, 16'h0000};
        vecs[7]  = '{1'b0, 8'h11, 16'h0000, 2'b00, 16'h5A00};
        vecs[8]  = '{1'b0, 8'hFF, 16'h0000, 2'b00, 16'h0000};
        vecs[9]  = '{1'b1, 8'h00, 16'h00A0, 2'b11, 16'h0000};
        vecs[10] = '{1'b1, 8'h01, 16'h00A1, 2'b11, 16'h0000};
        vecs[11] = '{1'b1, 8'h02, 16'h00A2, 2'b11, 16'h0000};
        vecs[12] = '{1'b1, 8'h03, 16'h00A3, 2'b11, 16'h0000};
        vecs[13] = '{1'b0, 8'h02, 16'h0000, 2'b00, 16'h00A2};

        // Reset values and the power-up sweep
        repeat (3) tick();
        check("reset outs a", {ready_a, rvalid_a, init_done_a, rdata_a}, 0);
        check("reset outs b", {ready_b, rvalid_b, init_done_b, rdata_b}, 0);
        clr_n = 1'b1;
        tick();
        check("sweep init_done low", init_done_a, 0);
        wait_ready(0, n);
        check("init sweep length", n, DEPTH);
        check("init_done a", init_done_a, 1);
        check("ready/init_done b", {ready_b, init_done_b}, 2'b11);

        for (int i = 0; i < 14; i++) do_op(vecs[i], i);

        // Write then read same address on the following edge
        req = 1'b1; we = 1'b1; addr = 8'h20; wdata = 16'hC0DE; wstrb = 2'b11;
        tick();
        we = 1'b0; wstrb = '0;
        tick();
        req = 1'b0;
        tick();
        check("raw a", {rvalid_a, rdata_a}, {1'b1, 16'hC0DE});
        tick();
        check("raw b", {rvalid_b, rdata_b}, {1'b1, 16'hC0DE});
        tick();

        // Four back-to-back reads
        for (int k = 0; k < 8; k++) begin
            if (k < 4) begin
                req = 1'b1; we = 1'b0; addr = AW'(k);
            end else begin
                req = 1'b0;
            end
            tick();
            va[k] = rvalid_a; da8[k] = rdata_a;
            vb[k] = rvalid_b; db8[k] = rdata_b;
        end
        check("b2b rvalid_a", va, 8'b0001_1110);
        check("b2b rvalid_b", vb, 8'b0011_1100);
        for (int j = 0; j < 4; j++) begin
            check($sformatf("b2b rdata_a %0d", j), da8[j+1], 16'h00A0 + DW'(j));
            check($sformatf("b2b rdata_b %0d", j), db8[j+2], 16'h00A0 + DW'(j));
        end
        tick();
        check("rdata hold a", {rvalid_a, rdata_a}, {1'b0, 16'h00A3});
        check("rdata hold b", {rvalid_b, rdata_b}, {1'b0, 16'h00A3});

        // Read in flight when a flush starts
        req = 1'b1; we = 1'b0; addr = 8'h01;
        tick();
        req = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush drain a", {rvalid_a, rdata_a}, {1'b1, 16'h00A1});
        check("flush ready low", ready_a, 0);
        tick();
        check("flush drain b", {rvalid_b, rdata_b}, {1'b1, 16'h00A1});
        wait_ready(1, n);
        check("flush sweep length", n, DEPTH);

        cnt_a = 0; cnt_b = 0; or_a = '0; or_b = '0;
        for (int k = 0; k < DEPTH + 4; k++) begin
            if (k < DEPTH) begin
                req = 1'b1; we = 1'b0; addr = AW'(k);
            end else begin
                req = 1'b0;
            end
            tick();
            if (rvalid_a) begin cnt_a++; or_a |= rdata_a; end
            if (rvalid_b) begin cnt_b++; or_b |= rdata_b; end
        end
        check("readback count a", cnt_a, DEPTH);
        check("readback count b", cnt_b, DEPTH);
        check("readback zero a", or_a, 0);
        check("readback zero b", or_b, 0);

        // Reset at sweep address 100
        flush = 1'b1;
        tick();
        flush = 1'b0;
        repeat (100) tick();
        clr_n = 1'b0;
        #1;
        check("midsweep reset a", {ready_a, rvalid_a, init_done_a, rdata_a}, 0);
        check("midsweep reset b", {ready_b, rvalid_b, init_done_b, rdata_b}, 0);
        tick();
        tick();
        clr_n = 1'b1;
        tick();
        wait_ready(0, n);
        check("midsweep restart length", n, DEPTH);

        // Reset with a read in flight
        req = 1'b1; we = 1'b0; addr = 8'h00;
        tick();
        req = 1'b0;
        clr_n = 1'b0;
        v_or = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            v_or |= rvalid_a | rvalid_b;
            tick();
        end
        clr_n = 1'b1;
        tick();
        v_or |= rvalid_a | rvalid_b;
        check("midread rvalid dropped", v_or, 0);
        wait_ready(0, n);
        check("midread restart length", n, DEPTH);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
